// File: rtl/powergate_switch_ack_emu.sv
// Power-switch ack emulator: per-domain request/ack handshake with ramp latency and inrush cap.
// Optional latency jitter when POWERGATE_ACK_JITTER_EN is defined.

module powergate_switch_ack_lane #(
  parameter int   CW        = 4,
  parameter logic RESET_ACK = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req,
  input  logic          i_grant,
  input  logic [CW-1:0] i_load,
  output logic          o_ack,
  output logic          o_busy,
  output logic          o_evt,
  output logic          o_cand,
  output logic          o_ramp
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RAMP} state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_ack, w_ack_nx;
  logic          r_evt, w_evt_nx;
  logic          w_mis;

  assign w_mis = i_req ^ r_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ack   <= RESET_ACK;
      r_evt   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_ack   <= w_ack_nx;
      r_evt   <= w_evt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_ack_nx   = r_ack;
    w_evt_nx   = 1'b0;
    case (r_state)
      S_RAMP: begin
        // Request withdrawn mid-ramp aborts silently; ack keeps its old level.
        if (!w_mis) begin
          w_state_nx = S_IDLE;
        end else if (r_cnt == '0) begin
          w_ack_nx   = ~r_ack;
          w_evt_nx   = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      default: begin
        if (!w_mis) begin
          w_state_nx = S_IDLE;
        end else if (i_grant) begin
          w_state_nx = S_RAMP;
          w_cnt_nx   = i_load;
        end else begin
          w_state_nx = S_WAIT;
        end
      end
    endcase
  end

  always_comb begin
    o_ack  = r_ack;
    o_evt  = r_evt;
    o_busy = (r_state != S_IDLE);
    o_ramp = (r_state == S_RAMP);
    o_cand = (r_state != S_RAMP) && w_mis;
  end
endmodule

module powergate_switch_ack_emu #(
  parameter int                   N_DOMAINS  = 4,
  parameter int                   LATENCY    = 15,
  parameter int                   MAX_ACTIVE = 1,
  parameter logic [N_DOMAINS-1:0] RESET_ACK  = '0,
  parameter int                   JITTER_W   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_DOMAINS-1:0] switch_i,
  output logic [N_DOMAINS-1:0] switch_ack_o,
  output logic [N_DOMAINS-1:0] busy_o,
  output logic [N_DOMAINS-1:0] ack_evt_o
);
`ifdef POWERGATE_ACK_JITTER_EN
  localparam int CW = $clog2(LATENCY + 2**JITTER_W);
  logic [15:0]   r_lfsr;
  logic [CW-1:0] w_load;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_load = CW'(LATENCY - 1) + CW'(r_lfsr[JITTER_W-1:0]);
`else
  localparam int CW = $clog2(LATENCY + 1);
  logic [CW-1:0] w_load;

  assign w_load = CW'(LATENCY - 1);
`endif

  logic [N_DOMAINS-1:0] w_grant, w_cand, w_ramp;

  // Slots are counted from the current state, so a slot freed on an edge is granted next cycle.
  always_comb begin
    int nr;
    int g;
    nr      = 0;
    g       = 0;
    w_grant = '0;
    for (int i = 0; i < N_DOMAINS; i++)
      if (w_ramp[i]) nr++;
    for (int i = 0; i < N_DOMAINS; i++) begin
      if (w_cand[i] && (g < MAX_ACTIVE - nr)) begin
        w_grant[i] = 1'b1;
        g++;
      end
    end
  end

  for (genvar gi = 0; gi < N_DOMAINS; gi++) begin : g_lane
    powergate_switch_ack_lane #(
      .CW        (CW),
      .RESET_ACK (RESET_ACK[gi])
    ) u_lane (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_req   (switch_i[gi]),
      .i_grant (w_grant[gi]),
      .i_load  (w_load),
      .o_ack   (switch_ack_o[gi]),
      .o_busy  (busy_o[gi]),
      .o_evt   (ack_evt_o[gi]),
      .o_cand  (w_cand[gi]),
      .o_ramp  (w_ramp[gi])
    );
  end
endmodule

// File: tb/tb_powergate_switch_ack_emu.sv
// Bench for powergate_switch_ack_emu: directed scenarios plus random toggling against a
// timestamp-based reference model (two configurations: L=15/MAX=1 and L=1/MAX=4).
module tb_powergate_switch_ack_emu;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = '0;
  logic [3:0] sw2 = '0;
  logic [3:0] ack, busy, evt, ack2, busy2, evt2;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;

  // Model: per domain the ack level and the edge at which its ramp completes (-1 = not ramping).
  logic [3:0] m_ack  [2];
  logic [3:0] m_busy [2];
  logic [3:0] m_evt  [2];
  int         m_end  [2][4];

  always #5 clk = ~clk;

  powergate_switch_ack_emu #(
    .N_DOMAINS(4), .LATENCY(15), .MAX_ACTIVE(1), .RESET_ACK(4'b0000), .JITTER_W(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .switch_i(sw),
    .switch_ack_o(ack), .busy_o(busy), .ack_evt_o(evt)
  );

  powergate_switch_ack_emu #(
    .N_DOMAINS(4), .LATENCY(1), .MAX_ACTIVE(4), .RESET_ACK(4'b0000), .JITTER_W(2)
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .switch_i(sw2),
    .switch_ack_o(ack2), .busy_o(busy2), .ack_evt_o(evt2)
  );

  task automatic model_edge(input int k, input logic [3:0] s, input logic r);
    int lat, mx, nr, g;
    lat = (k == 0) ? 15 : 1;
    mx  = (k == 0) ? 1 : 4;
    m_evt[k] = '0;
    if (r) begin
      m_ack[k]  = '0;
      m_busy[k] = '0;
      for (int i = 0; i < 4; i++) m_end[k][i] = -1;
      return;
    end
    nr = 0;
    g  = 0;
    for (int i = 0; i < 4; i++) if (m_end[k][i] >= 0) nr++;
    for (int i = 0; i < 4; i++) begin
      if (m_end[k][i] < 0) begin
        if (s[i] != m_ack[k][i]) begin
          m_busy[k][i] = 1'b1;
          if (g < mx - nr) begin
            m_end[k][i] = t + lat;
            g++;
          end
        end else begin
          m_busy[k][i] = 1'b0;
        end
      end else if (s[i] == m_ack[k][i]) begin
        m_end[k][i]  = -1;
        m_busy[k][i] = 1'b0;
      end else if (t == m_end[k][i]) begin
        m_ack[k][i]  = ~m_ack[k][i];
        m_evt[k][i]  = 1'b1;
        m_end[k][i]  = -1;
        m_busy[k][i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0, sw, rst);
    model_edge(1, sw2, rst);
    t++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++; if (ack !== 4'b0000)  begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    n_tests++; if (busy !== 4'b0000) begin n_fail++; $display("FAIL reset_busy got=%b exp=0000", busy); end
    n_tests++; if (evt !== 4'b0000)  begin n_fail++; $display("FAIL reset_evt got=%b exp=0000", evt); end
    n_tests++; if (ack2 !== 4'b0000 || busy2 !== 4'b0000) begin
      n_fail++; $display("FAIL reset_dut2 ack=%b busy=%b exp=0000/0000", ack2, busy2);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int rise = -1, nev = 0;
    logic busy_ok = 1'b1;
    sw = 4'b0001;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (ack[0] && rise < 0) rise = e;
      if (evt[0]) nev++;
      if ((e < 15) != busy[0]) busy_ok = 1'b0;
    end
    n_tests++; if (rise != 15) begin n_fail++; $display("FAIL single_latency got=%0d exp=15", rise); end
    n_tests++; if (nev != 1)   begin n_fail++; $display("FAIL single_evt_count got=%0d exp=1", nev); end
    n_tests++; if (!busy_ok)   begin n_fail++; $display("FAIL single_busy_window got=0 exp=1"); end
    sw = 4'b0000;
    for (int e = 0; e < 20; e++) tick();
    n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_off got=%b exp=0000", ack); end
  endtask

  task automatic test_two();
    int r1 = -1, r2 = -1;
    logic busy_ok = 1'b1;
    sw = 4'b0110;
    for (int e = 0; e < 35; e++) begin
      tick();
      if (ack[1] && r1 < 0) r1 = e;
      if (ack[2] && r2 < 0) r2 = e;
      if ((e < 31) != busy[2]) busy_ok = 1'b0;
    end
    n_tests++; if (r1 != 15) begin n_fail++; $display("FAIL two_ack1 got=%0d exp=15", r1); end
    n_tests++; if (r2 != 31) begin n_fail++; $display("FAIL two_ack2 got=%0d exp=31", r2); end
    n_tests++; if (!busy_ok) begin n_fail++; $display("FAIL two_busy2 got=0 exp=1"); end
    sw = 4'b0000;
    for (int e = 0; e < 40; e++) tick();
    n_tests++; if (ack !== 4'b0000 || busy !== 4'b0000) begin
      n_fail++; $display("FAIL two_off ack=%b busy=%b exp=0000/0000", ack, busy);
    end
  endtask

  task automatic test_abort();
    int rise = -1, nev = 0;
    sw = 4'b0001;
    for (int e = 0; e < 5; e++) begin tick(); if (evt[0]) nev++; end
    sw = 4'b0000;
    tick();
    n_tests++; if (busy[0] !== 1'b0 || ack[0] !== 1'b0) begin
      n_fail++; $display("FAIL abort_state busy=%b ack=%b exp=0/0", busy[0], ack[0]);
    end
    sw = 4'b0010;
    tick();
    for (int e = 7; e < 26; e++) begin
      tick();
      if (ack[1] && rise < 0) rise = e;
      if (evt[0]) nev++;
    end
    n_tests++; if (rise != 21) begin n_fail++; $display("FAIL abort_slot_reuse got=%0d exp=21", rise); end
    n_tests++; if (nev != 0 || ack[0] !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_evt evts=%0d ack0=%b exp=0/0", nev, ack[0]);
    end
    sw = 4'b0000;
    for (int e = 0; e < 20; e++) tick();
  endtask

  task automatic test_reset_mid();
    int rise = -1;
    sw = 4'b0001;
    for (int e = 0; e < 8; e++) tick();
    rst = 1'b1;
    tick();
    n_tests++; if (ack !== 4'b0000 || busy !== 4'b0000 || evt !== 4'b0000) begin
      n_fail++; $display("FAIL midreset ack=%b busy=%b evt=%b exp=0000", ack, busy, evt);
    end
    rst = 1'b0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (ack[0] && rise < 0) rise = e;
    end
    n_tests++; if (rise != 15) begin n_fail++; $display("FAIL midreset_latency got=%0d exp=15", rise); end
    sw = 4'b0000;
    for (int e = 0; e < 20; e++) tick();
  endtask

  task automatic test_all_fast();
    sw2 = 4'b1111;
    tick();
    n_tests++; if (busy2 !== 4'b1111 || ack2 !== 4'b0000) begin
      n_fail++; $display("FAIL fast_enter busy=%b ack=%b exp=1111/0000", busy2, ack2);
    end
    tick();
    n_tests++; if (ack2 !== 4'b1111) begin n_fail++; $display("FAIL fast_ack got=%b exp=1111", ack2); end
    n_tests++; if (evt2 !== 4'b1111) begin n_fail++; $display("FAIL fast_evt got=%b exp=1111", evt2); end
    tick();
    n_tests++; if (evt2 !== 4'b0000) begin n_fail++; $display("FAIL fast_evt_pulse got=%b exp=0000", evt2); end
    sw2 = 4'b0000;
    for (int e = 0; e < 3; e++) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(5) == 0) sw[$urandom_range(3)] = ~sw[$urandom_range(3)];
      if ($urandom_range(1) == 0) sw2 = 4'($urandom);
      tick();
      n_tests++; if (ack !== m_ack[0] || busy !== m_busy[0] || evt !== m_evt[0]) begin
        n_fail++;
        $display("FAIL rand_dut1 cyc=%0d ack=%b busy=%b evt=%b exp=%b/%b/%b",
                 c, ack, busy, evt, m_ack[0], m_busy[0], m_evt[0]);
      end
      n_tests++; if (ack2 !== m_ack[1] || busy2 !== m_busy[1] || evt2 !== m_evt[1]) begin
        n_fail++;
        $display("FAIL rand_dut2 cyc=%0d ack=%b busy=%b evt=%b exp=%b/%b/%b",
                 c, ack2, busy2, evt2, m_ack[1], m_busy[1], m_evt[1]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_ack[k] = '0; m_busy[k] = '0; m_evt[k] = '0;
      for (int i = 0; i < 4; i++) m_end[k][i] = -1;
    end
    test_reset();
    test_single();
    test_two();
    test_abort();
    test_reset_mid();
    test_all_fast();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
